// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampling SPI slave.
package spi_pkg;

    typedef enum logic [0:0] {IDLE, ACTIVE} spi_state_t;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DATA_W_MAX  = 32;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage input synchroniser with single-cycle rise/fall pulses on the synchronised value.
module spi_in_sync
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the clk domain: all CPOL/CPHA modes, bursts, buffered RX/TX.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso_o,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              overrun,
    output logic              underrun,
    input  logic              status_clr
);

    localparam int unsigned CNT_W = $clog2(DATA_W_MAX);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t LAST_BIT = cnt_t'(DATA_W - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_edges;

    // ss_n resets low so a frame can only start after the pin has been seen high.
    spi_in_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (sclk),
        .sync_o (sclk_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_in_sync #(.RESET_VAL(1'b0)) u_ss_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (ss_n),
        .sync_o (ss_s),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    spi_in_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (mosi),
        .sync_o (mosi_s),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    assign unused_edges = ^{sclk_s, mosi_rise, mosi_fall};

    spi_state_t        state_q, state_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d;
    cnt_t              bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shreg_q, rx_shreg_d, tx_shreg_q, tx_shreg_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d, tx_hold_q, tx_hold_d;
    logic              rx_full_q, rx_full_d, tx_full_q, tx_full_d;
    logic              skip_q, skip_d;
    logic              overrun_q, overrun_d, underrun_q, underrun_d;

    logic              lead, trail, sample_edge, shift_edge, word_done, tx_load;
    logic [DATA_W-1:0] rx_word, tx_shifted;

    assign lead        = cpol_q ? sclk_fall : sclk_rise;
    assign trail       = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = (state_q == ACTIVE) && (cpha_q ? trail : lead);
    assign shift_edge  = (state_q == ACTIVE) && (cpha_q ? lead : trail);
    assign word_done   = sample_edge && (bit_cnt_q == LAST_BIT);
    assign rx_word     = LSB_FIRST ? {mosi_s, rx_shreg_q[DATA_W-1:1]}
                                   : {rx_shreg_q[DATA_W-2:0], mosi_s};
    assign tx_shifted  = LSB_FIRST ? (tx_shreg_q >> 1) : (tx_shreg_q << 1);

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shreg_d = rx_shreg_q;
        tx_shreg_d = tx_shreg_q;
        rx_data_d  = rx_data_q;
        tx_hold_d  = tx_hold_q;
        rx_full_d  = rx_full_q;
        tx_full_d  = tx_full_q;
        skip_d     = skip_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        tx_load    = 1'b0;

        if (rx_full_q && rx_ready) begin
            rx_full_d = 1'b0;
        end
        if (tx_valid && !tx_full_q) begin
            tx_hold_d = tx_data;
            tx_full_d = 1'b1;
        end
        if (status_clr) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    bit_cnt_d  = '0;
                    rx_shreg_d = '0;
                    skip_d     = 1'b0;
                    tx_load    = !cpha;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    skip_d    = 1'b0;
                    if (bit_cnt_q != '0) begin
                        rx_shreg_d = '0;
                        tx_shreg_d = '0;
                    end
                end else begin
                    if (sample_edge) begin
                        rx_shreg_d = rx_word;
                        bit_cnt_d  = word_done ? '0 : bit_cnt_q + cnt_t'(1);
                        if (word_done) begin
                            if (!rx_full_q || rx_ready) begin
                                rx_data_d = rx_word;
                                rx_full_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                    end
                    // The first leading edge of a CPHA=1 word loads instead of shifting.
                    if (shift_edge) begin
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else if (!(cpha_q && bit_cnt_q == '0)) begin
                            tx_shreg_d = tx_shifted;
                        end
                    end
                    if (!cpha_q && word_done) begin
                        tx_load = 1'b1;
                        skip_d  = 1'b1;
                    end
                    if (cpha_q && lead && bit_cnt_q == '0) begin
                        tx_load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (tx_load) begin
            if (tx_full_q) begin
                tx_shreg_d = tx_hold_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shreg_d = '0;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            bit_cnt_q  <= '0;
            rx_shreg_q <= '0;
            tx_shreg_q <= '0;
            rx_data_q  <= '0;
            tx_hold_q  <= '0;
            rx_full_q  <= 1'b0;
            tx_full_q  <= 1'b0;
            skip_q     <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shreg_q <= rx_shreg_d;
            tx_shreg_q <= tx_shreg_d;
            rx_data_q  <= rx_data_d;
            tx_hold_q  <= tx_hold_d;
            rx_full_q  <= rx_full_d;
            tx_full_q  <= tx_full_d;
            skip_q     <= skip_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    // busy tracks the synchronised ss_n, but only for frames that were properly started.
    assign busy     = ((state_q == ACTIVE) && !ss_s) || ss_fall;
    assign miso_oe  = busy;
    assign miso_o   = busy && (LSB_FIRST ? tx_shreg_q[0] : tx_shreg_q[DATA_W-1]);
    assign tx_ready = !tx_full_q;
    assign rx_valid = rx_full_q;
    assign rx_data  = rx_data_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench: a 16-bit MSB-first slave and an 8-bit LSB-first slave on a shared SPI bus.
`timescale 1ns/1ps
module tb_spi_slave_sync;

    localparam time HALF = 80ns;

    logic clk = 1'b0;
    logic reset_n, cpol, cpha, sclk, mosi, ss16_n, ss8_n, status_clr;
    logic miso16, oe16, txr16, rxv16, rxr16, txv16, busy16, ovr16, und16;
    logic miso8, oe8, txr8, rxv8, rxr8, txv8, busy8, ovr8, und8;
    logic [15:0] txd16, rxd16;
    logic [7:0]  txd8, rxd8;
    logic        sel8;
    int          n_checks = 0;
    int          n_fail = 0;
    time         t_lead = 0;
    time         t_rxv16 = 0;
    logic [31:0] g1, g2, g3;

    always #5 clk = ~clk;
    always @(posedge rxv16) t_rxv16 = $time;

    spi_slave_sync #(.DATA_W(16), .LSB_FIRST(1'b0)) dut16 (
        .clk(clk), .reset_n(reset_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss16_n),
        .mosi(mosi), .miso_o(miso16), .miso_oe(oe16), .tx_data(txd16), .tx_valid(txv16),
        .tx_ready(txr16), .rx_data(rxd16), .rx_valid(rxv16), .rx_ready(rxr16), .busy(busy16),
        .overrun(ovr16), .underrun(und16), .status_clr(status_clr)
    );

    spi_slave_sync #(.DATA_W(8), .LSB_FIRST(1'b1)) dut8 (
        .clk(clk), .reset_n(reset_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss8_n),
        .mosi(mosi), .miso_o(miso8), .miso_oe(oe8), .tx_data(txd8), .tx_valid(txv8),
        .tx_ready(txr8), .rx_data(rxd8), .rx_valid(rxv8), .rx_ready(rxr8), .busy(busy8),
        .overrun(ovr8), .underrun(und8), .status_clr(status_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx16_put(input logic [15:0] d);
        @(negedge clk);
        txd16 = d;
        txv16 = 1'b1;
        @(negedge clk);
        txv16 = 1'b0;
    endtask

    task automatic tx8_put(input logic [7:0] d);
        @(negedge clk);
        txd8 = d;
        txv8 = 1'b1;
        @(negedge clk);
        txv8 = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
    endtask

    task automatic pulse_rxr16();
        @(negedge clk);
        rxr16 = 1'b1;
        @(negedge clk);
        rxr16 = 1'b0;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        wait_clk(6);
    endtask

    // Master side: drives MOSI/SCLK for nbits of a w-bit word and collects MISO.
    task automatic xfer(input int nbits, input int w, input bit lsb, input logic [31:0] mo,
                        output logic [31:0] mi);
        int idx;
        mi = '0;
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : w - 1 - i;
            if (!cpha) begin
                mosi = mo[idx];
                #HALF;
                mi[idx] = sel8 ? miso8 : miso16;
                sclk = ~cpol;
                t_lead = $time;
                #HALF;
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                t_lead = $time;
                mosi = mo[idx];
                #HALF;
                mi[idx] = sel8 ? miso8 : miso16;
                sclk = cpol;
                #HALF;
            end
        end
    endtask

    task automatic frame_end16();
        if (!cpha) #HALF;
        ss16_n = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        reset_n = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; mosi = 1'b0;
        ss16_n = 1'b1; ss8_n = 1'b1; status_clr = 1'b0; sel8 = 1'b0;
        txd16 = '0; txv16 = 1'b0; rxr16 = 1'b0; txd8 = '0; txv8 = 1'b0; rxr8 = 1'b0;
        wait_clk(3);
        check("rst_miso", miso16, 0);
        check("rst_oe", oe16, 0);
        check("rst_tx_ready", txr16, 1);
        check("rst_rx_valid", rxv16, 0);
        check("rst_rx_data", rxd16, 0);
        check("rst_busy", busy16, 0);
        check("rst_flags", {ovr16, und16}, 0);
        reset_n = 1'b1;
        wait_clk(5);

        // Mode 0, 16-bit MSB first
        tx16_put(16'hA55A);
        check("m0_tx_full", txr16, 0);
        ss16_n = 1'b0;
        wait_clk(8);
        check("m0_busy", busy16, 1);
        check("m0_oe", oe16, 1);
        check("m0_tx_taken", txr16, 1);
        xfer(16, 16, 1'b0, 32'h1234, g1);
        check("m0_miso", g1, 32'hA55A);
        check("m0_rx_data", rxd16, 32'h1234);
        check("m0_rx_valid", rxv16, 1);
        check("m0_rx_latency", 32'(t_rxv16 - t_lead), 32'd25);
        frame_end16();
        check("m0_idle_busy", busy16, 0);
        check("m0_idle_oe", oe16, 0);
        check("m0_idle_miso", miso16, 0);
        // the word-completion load found TX empty
        check("m0_underrun", und16, 1);
        pulse_clr();
        pulse_rxr16();
        check("m0_rx_drained", rxv16, 0);
        check("m0_flags_clr", {ovr16, und16}, 0);

        // All four modes on the 8-bit LSB-first slave
        sel8 = 1'b1;
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0]);
            tx8_put(8'hC3);
            ss8_n = 1'b0;
            wait_clk(8);
            xfer(8, 8, 1'b1, 32'h3C, g1);
            if (!cpha) #HALF;
            ss8_n = 1'b1;
            wait_clk(6);
            check($sformatf("mode%0d_miso", m), g1, 32'hC3);
            check($sformatf("mode%0d_rx_data", m), rxd8, 32'h3C);
            check($sformatf("mode%0d_rx_valid", m), rxv8, 1);
            @(negedge clk);
            rxr8 = 1'b1;
            @(negedge clk);
            rxr8 = 1'b0;
        end
        sel8 = 1'b0;

        // Mode 3 three-word burst with TX refilled between words
        set_mode(1'b1, 1'b1);
        pulse_clr();
        rxr16 = 1'b1;
        tx16_put(16'h0001);
        ss16_n = 1'b0;
        wait_clk(8);
        xfer(16, 16, 1'b0, 32'h1111, g1);
        tx16_put(16'h0002);
        xfer(16, 16, 1'b0, 32'h2222, g2);
        tx16_put(16'h0003);
        xfer(16, 16, 1'b0, 32'h3333, g3);
        frame_end16();
        rxr16 = 1'b0;
        check("burst_w1", g1, 32'h0001);
        check("burst_w2", g2, 32'h0002);
        check("burst_w3", g3, 32'h0003);
        check("burst_rx_last", rxd16, 32'h3333);
        check("burst_flags", {ovr16, und16}, 0);
        check("burst_tx_ready", txr16, 1);

        // Underrun and overrun over a mode 0 two-word burst
        set_mode(1'b0, 1'b0);
        ss16_n = 1'b0;
        wait_clk(8);
        xfer(16, 16, 1'b0, 32'hAAAA, g1);
        xfer(16, 16, 1'b0, 32'h5555, g2);
        frame_end16();
        check("uo_miso_w1", g1, 0);
        check("uo_miso_w2", g2, 0);
        check("uo_underrun", und16, 1);
        check("uo_overrun", ovr16, 1);
        check("uo_rx_keep", rxd16, 32'hAAAA);
        check("uo_rx_valid", rxv16, 1);
        pulse_clr();
        check("uo_clr", {ovr16, und16}, 0);
        pulse_rxr16();

        // Abort after 5 bits, then a full frame
        tx16_put(16'h1357);
        ss16_n = 1'b0;
        wait_clk(8);
        xfer(5, 16, 1'b0, 32'hFFFF, g1);
        frame_end16();
        check("abort_no_rx", rxv16, 0);
        check("abort_flags", {ovr16, und16}, 0);
        ss16_n = 1'b0;
        wait_clk(8);
        xfer(16, 16, 1'b0, 32'hBEEF, g1);
        frame_end16();
        check("abort_next_rx", rxd16, 32'hBEEF);
        check("abort_next_valid", rxv16, 1);
        check("abort_next_miso", g1, 0);
        pulse_rxr16();

        // Reset in the middle of a frame
        tx16_put(16'h7777);
        ss16_n = 1'b0;
        wait_clk(8);
        xfer(3, 16, 1'b0, 32'hFFFF, g1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mrst_busy", busy16, 0);
        check("mrst_oe", oe16, 0);
        check("mrst_miso", miso16, 0);
        check("mrst_tx_ready", txr16, 1);
        check("mrst_rx", {rxv16, rxd16}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_clk(10);
        check("mrst_wait_ss_high", busy16, 0);
        ss16_n = 1'b1;
        wait_clk(6);
        tx16_put(16'h1234);
        ss16_n = 1'b0;
        wait_clk(8);
        xfer(16, 16, 1'b0, 32'h0F0F, g1);
        frame_end16();
        check("mrst_resume_miso", g1, 32'h1234);
        check("mrst_resume_rx", rxd16, 32'h0F0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
